// File: rtl/mem_access_ctrl_pkg.sv
// Shared op codes, FSM states and special-function register addresses for the
// data-RAM access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_COPY  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        FILL,
        CP_RD,
        CP_WR,
        RESP
    } state_e;

    localparam logic [10:0] WREG_ADDR     = 11'h200;
    localparam logic [10:0] CARRY_ADDR    = 11'h201;
    localparam logic [10:0] ZERO_ADDR     = 11'h202;
    localparam logic [10:0] INDIRECT_ADDR = 11'h203;
    localparam logic [10:0] POINTER_ADDR  = 11'h204;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side command/response channel of the RAM access controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_src;
    logic [ADDR_W-1:0] req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_src, req_len, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_src, req_len, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl_sfr_range_check.sv
// Flags whether the wrapping address range [base, base+len-1] touches the
// special-function register window.
module sfr_range_check #(
    parameter int                 ADDR_W   = 11,
    parameter logic [ADDR_W-1:0]  SFR_BASE = 'h200,
    parameter int                 SFR_SIZE = 16
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              hit
);
    localparam logic [ADDR_W:0] SIZE = (ADDR_W+1)'(SFR_SIZE);

    logic [ADDR_W-1:0] to_win;
    logic [ADDR_W-1:0] into_win;

    // Either the range starts inside the window, or walking forward from base
    // (modulo the address space) reaches the window start before len runs out.
    assign to_win   = SFR_BASE - base;
    assign into_win = base - SFR_BASE;
    assign hit      = (len != '0) && ((to_win < len) || ({1'b0, into_win} < SIZE));
endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side data-RAM controller: single read/write, block fill and block
// copy, hiding the RAM's one-cycle synchronous read latency from the core.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 11,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] SFR_BASE = 'h200,
    parameter int                SFR_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset_bar,
    mem_access_ctrl_if.slave    bus,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_rdata
);
    state_e            state;
    op_e               op;
    logic [ADDR_W-1:0] dst, src, cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q, rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              dst_hit, src_hit, reject;

    assign op = op_e'(bus.req_op);

    sfr_range_check #(.ADDR_W(ADDR_W), .SFR_BASE(SFR_BASE), .SFR_SIZE(SFR_SIZE)) u_dst_chk (
        .base (bus.req_addr),
        .len  (bus.req_len),
        .hit  (dst_hit)
    );

    sfr_range_check #(.ADDR_W(ADDR_W), .SFR_BASE(SFR_BASE), .SFR_SIZE(SFR_SIZE)) u_src_chk (
        .base (bus.req_src),
        .len  (bus.req_len),
        .hit  (src_hit)
    );

    assign reject = ((op == OP_FILL) && dst_hit) ||
                    ((op == OP_COPY) && (dst_hit || src_hit));

    // Copy data comes straight from the RAM output, which is valid during CP_WR
    // but not yet at the edge that enters CP_WR.
    assign mem_wdata = (state == CP_WR) ? mem_rdata : wdata_q;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state       <= IDLE;
            dst         <= '0;
            src         <= '0;
            cnt         <= '0;
            wdata_q     <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            ready_q     <= 1'b1;
            busy        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        dst     <= bus.req_addr;
                        src     <= bus.req_src;
                        cnt     <= bus.req_len;
                        wdata_q <= bus.req_wdata;
                        case (op)
                            OP_READ: begin
                                mem_addr <= bus.req_addr;
                                state    <= RD_ADDR;
                            end
                            OP_WRITE: begin
                                mem_addr <= bus.req_addr;
                                mem_we   <= 1'b1;
                                state    <= WR;
                            end
                            default: begin
                                if (reject || bus.req_len == '0) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= reject;
                                    state       <= RESP;
                                end else if (op == OP_FILL) begin
                                    mem_addr <= bus.req_addr;
                                    mem_we   <= 1'b1;
                                    state    <= FILL;
                                end else begin
                                    mem_addr <= bus.req_src;
                                    state    <= CP_RD;
                                end
                            end
                        endcase
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    rsp_data_q  <= mem_rdata;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                WR: begin
                    mem_we      <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                FILL: begin
                    if (cnt == 1) begin
                        mem_we      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        dst      <= dst + 1'b1;
                        mem_addr <= dst + 1'b1;
                        cnt      <= cnt - 1'b1;
                    end
                end
                CP_RD: begin
                    mem_addr <= dst;
                    mem_we   <= 1'b1;
                    state    <= CP_WR;
                end
                CP_WR: begin
                    mem_we <= 1'b0;
                    if (cnt == 1) begin
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        src      <= src + 1'b1;
                        dst      <= dst + 1'b1;
                        cnt      <= cnt - 1'b1;
                        mem_addr <= src + 1'b1;
                        state    <= CP_RD;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    ready_q     <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    mem_we  <= 1'b0;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural RAM and a scoreboard
// of expected responses built from a shadow memory.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW = 11;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_bar = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          busy, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SFR_BASE(11'h200), .SFR_SIZE(16)) dut (
        .clk       (clk),
        .reset_bar (reset_bar),
        .bus       (bus),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // RAM with one-cycle read latency and the indirect register at 0x203
    logic [DW-1:0] ram   [0:2047];
    logic [DW-1:0] model [0:2047];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_addr == INDIRECT_ADDR) mem_rdata <= ram[ram[POINTER_ADDR][AW-1:0]];
        else                           mem_rdata <= ram[mem_addr];
    end

    rsp_t          sb[$];
    logic [AW-1:0] waddrs[$];
    int            checks = 0;
    int            errors = 0;
    logic [1:0]    l_op;
    logic [AW-1:0] l_a, l_s, l_n;
    logic [DW-1:0] l_d;
    logic          l_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_sfr(input logic [AW-1:0] a);
        return (a >= 11'h200) && (a <= 11'h20F);
    endfunction

    function automatic logic range_hits(input logic [AW-1:0] base, input logic [AW-1:0] n);
        for (int k = 0; k < int'(n); k++)
            if (in_sfr(AW'(int'(base) + k))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == 11'h203) return model[model[11'h204][AW-1:0]];
        return model[a];
    endfunction

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] s,
                         input logic [AW-1:0] n, input logic [DW-1:0] d);
        rsp_t e;
        int   guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_src   = s;
        bus.req_len   = n;
        bus.req_wdata = d;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        e.err  = (op == 2'b10 && range_hits(a, n)) ||
                 (op == 2'b11 && (range_hits(a, n) || range_hits(s, n)));
        e.data = (op == 2'b00) ? rd_model(a) : '0;
        sb.push_back(e);
        l_op = op; l_a = a; l_s = s; l_n = n; l_d = d; l_err = e.err;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_src   = AW'($urandom);
        bus.req_len   = AW'($urandom);
        bus.req_wdata = DW'($urandom);
    endtask

    task automatic wait_rsp(input string tag, output int lat, output int wes);
        rsp_t e;
        lat = 0;
        wes = 0;
        waddrs.delete();
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            if (mem_we) begin
                wes++;
                waddrs.push_back(mem_addr);
            end
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(lat != 0), 32'd1);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '0;
        if (lat != 0) begin
            chk({tag, "_data"}, 32'(bus.rsp_data), 32'(e.data));
            chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
            @(negedge clk);
            chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    task automatic apply_model();
        if (l_err) return;
        case (l_op)
            2'b01: model[l_a] = l_d;
            2'b10: for (int k = 0; k < int'(l_n); k++) model[AW'(int'(l_a) + k)] = l_d;
            2'b11: for (int k = 0; k < int'(l_n); k++)
                       model[AW'(int'(l_a) + k)] = model[AW'(int'(l_s) + k)];
            default: ;
        endcase
    endtask

    task automatic cmd(input string tag, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] s, input logic [AW-1:0] n, input logic [DW-1:0] d,
                       output int lat, output int wes);
        issue(op, a, s, n, d);
        wait_rsp(tag, lat, wes);
        apply_model();
    endtask

    initial begin
        int lat, wes, stray;
        for (int i = 0; i < 2048; i++) begin
            ram[i]   = DW'(i * 16'h0123) ^ 16'hA5A5;
            model[i] = DW'(i * 16'h0123) ^ 16'hA5A5;
        end
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_src   = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;

        #12;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        reset_bar = 1'b1;

        cmd("wr0", 2'b01, 11'h000, '0, '0, 16'hDEAD, lat, wes);
        chk("wr0_lat", 32'(lat), 32'd2);
        chk("wr0_we_cycles", 32'(wes), 32'd1);
        chk("wr0_addr", 32'(waddrs[0]), 32'h000);
        cmd("rd0", 2'b00, 11'h000, '0, '0, '0, lat, wes);
        chk("rd0_lat", 32'(lat), 32'd3);
        chk("rd0_we_cycles", 32'(wes), 32'd0);

        cmd("fill_wrap", 2'b10, 11'h7FE, '0, 11'd4, 16'hBEEF, lat, wes);
        chk("fill_wrap_lat", 32'(lat), 32'd5);
        chk("fill_wrap_we_cycles", 32'(wes), 32'd4);
        if (waddrs.size() == 4) begin
            chk("fill_wa0", 32'(waddrs[0]), 32'h7FE);
            chk("fill_wa1", 32'(waddrs[1]), 32'h7FF);
            chk("fill_wa2", 32'(waddrs[2]), 32'h000);
            chk("fill_wa3", 32'(waddrs[3]), 32'h001);
        end
        cmd("rd001", 2'b00, 11'h001, '0, '0, '0, lat, wes);
        cmd("rd002", 2'b00, 11'h002, '0, '0, '0, lat, wes);

        cmd("seed0", 2'b01, 11'h000, '0, '0, 16'h1111, lat, wes);
        cmd("seed1", 2'b01, 11'h001, '0, '0, 16'h2222, lat, wes);
        cmd("seed2", 2'b01, 11'h002, '0, '0, 16'h3333, lat, wes);
        cmd("copy", 2'b11, 11'h100, 11'h000, 11'd3, '0, lat, wes);
        chk("copy_lat", 32'(lat), 32'd7);
        chk("copy_we_cycles", 32'(wes), 32'd3);
        if (waddrs.size() == 3) chk("copy_wa2", 32'(waddrs[2]), 32'h102);
        cmd("rd100", 2'b00, 11'h100, '0, '0, '0, lat, wes);
        cmd("rd101", 2'b00, 11'h101, '0, '0, '0, lat, wes);
        cmd("rd102", 2'b00, 11'h102, '0, '0, '0, lat, wes);

        cmd("fill_sfr", 2'b10, 11'h1FE, '0, 11'd4, 16'h5555, lat, wes);
        chk("fill_sfr_lat", 32'(lat), 32'd1);
        chk("fill_sfr_we_cycles", 32'(wes), 32'd0);
        cmd("rd1fe", 2'b00, 11'h1FE, '0, '0, '0, lat, wes);

        cmd("ptr_wr", 2'b01, 11'h204, '0, '0, 16'h0001, lat, wes);
        cmd("rd_ind", 2'b00, 11'h203, '0, '0, '0, lat, wes);
        cmd("fill_len0", 2'b10, 11'h050, '0, 11'd0, 16'h7777, lat, wes);
        chk("fill_len0_lat", 32'(lat), 32'd1);
        chk("fill_len0_we_cycles", 32'(wes), 32'd0);

        cmd("fill_below", 2'b10, 11'h1FC, '0, 11'd4, 16'h4444, lat, wes);
        chk("fill_below_we_cycles", 32'(wes), 32'd4);
        cmd("rd1ff", 2'b00, 11'h1FF, '0, '0, '0, lat, wes);
        cmd("fill_above", 2'b10, 11'h210, '0, 11'd2, 16'h6666, lat, wes);
        cmd("fill_wrap_sfr", 2'b10, 11'h7FF, '0, 11'h202, 16'h9999, lat, wes);
        chk("fill_wrap_sfr_we", 32'(wes), 32'd0);
        cmd("copy_src_sfr", 2'b11, 11'h500, 11'h1F8, 11'h010, '0, lat, wes);
        chk("copy_src_sfr_we", 32'(wes), 32'd0);

        // abort a copy mid-write; its partial effect lands only in 0x300.. which is never read
        issue(2'b11, 11'h300, 11'h010, 11'd8, '0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        chk("abort_we_before", 32'(mem_we), 32'd1);
        #2 reset_bar = 1'b0;
        #1;
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        reset_bar = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) stray++;
        end
        chk("abort_no_rsp", 32'(stray), 32'd0);
        cmd("rd_after_rst", 2'b00, 11'h000, '0, '0, '0, lat, wes);
        chk("rd_after_rst_lat", 32'(lat), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller that drives the data RAM's addr/in_data/write_enable port and consumes its out_data. Accepts single read/write, block fill and block copy commands from the core over a valid/ready request channel. Returns one response per command. Sequences the RAM's one-cycle synchronous read latency so the core never sees RAM timing. Sits between the execute stage and the ram instance, in place of direct core drive.

Parameters:
ADDR_W, 11, RAM word-address width
DATA_W, 16, RAM data width
SFR_BASE, 11'h200, first address of special-function window (wreg, carry, zero, indirect, pointer)
SFR_SIZE, 16, words in SFR window (0x200-0x20F)

Ports:
clk  in  1  system clock, rising edge
reset_bar  in  1  asynchronous active-low reset
req_valid  in  1  command present
req_ready  out  1  controller can accept; transfer on req_valid&req_ready at rising edge
req_op  in  2  00 read, 01 write, 10 fill, 11 copy
req_addr  in  ADDR_W  target / destination address
req_src  in  ADDR_W  copy source address (ignored otherwise)
req_len  in  ADDR_W  word count for fill/copy (ignored otherwise)
req_wdata  in  DATA_W  write / fill data
rsp_valid  out  1  one-cycle response strobe
rsp_data  out  DATA_W  read data (read op); 0 otherwise
rsp_err  out  1  qualified by rsp_valid; block op rejected
busy  out  1  command in progress (not IDLE)
mem_addr  out  ADDR_W  to ram addr
mem_wdata  out  DATA_W  to ram in_data
mem_we  out  1  to ram write_enable
mem_rdata  in  DATA_W  from ram out_data; valid the cycle after mem_addr is presented

Behaviour:
- Reset (async, reset_bar low): state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_data=0; mem_we=0, mem_addr=0, mem_wdata=0; busy=0; counters 0. Reset mid-command aborts immediately; no response is issued afterwards. mem_we drops asynchronously.
- req_ready=1 only in IDLE. All req_* are captured at acceptance and may change afterwards.
- States: IDLE, RD_ADDR, RD_DATA, WR, FILL, CP_RD, CP_WR, RESP.
- Read: accept at edge E0. RD_ADDR drives mem_addr. Edge E1 moves to RD_DATA. mem_rdata is registered into rsp_data at E2. RESP holds rsp_valid=1 for one cycle. Read latency is 3 cycles from the accept edge to rsp_valid.
- Write: WR drives mem_addr/mem_wdata with mem_we=1 for exactly one cycle. RESP follows with rsp_data=0.
- Fill: writes req_wdata to addr, addr+1, ... for req_len words, one per cycle, mem_we held high. RESP follows the last write.
- Copy: per word, CP_RD presents src and CP_WR writes mem_rdata to dst (2 cycles per word). Then src++, dst++. RESP after the last word.
- Address arithmetic is modulo 2^ADDR_W (0x7FF+1 wraps to 0x000). The counter decrements per word, and the op is done when it reaches 0.
- req_len=0 on fill/copy: no RAM access; RESP next cycle with rsp_err=0.
- SFR protection: a fill or copy whose destination range or copy source range, including wrap, intersects [SFR_BASE, SFR_BASE+SFR_SIZE-1] is rejected. The check is done at acceptance. No RAM access occurs; RESP next cycle with rsp_err=1.
- Single read/write to the SFR window is allowed (e.g. indirect 0x203, carry 0x201).
- mem_we is never high outside WR, FILL, CP_WR. mem_addr holds its last value when idle.
- Back-to-back: next command can be accepted in the cycle after RESP (IDLE). Minimum spacing is 3 cycles for a write and 4 cycles for a read.

Decomposition:
- Package mem_ctrl_pkg holds the op codes (OP_READ, OP_WRITE, OP_FILL, OP_COPY) and the state enum. It also holds the SFR address constants: WREG_ADDR=0x200, CARRY_ADDR=0x201, ZERO_ADDR=0x202, INDIRECT_ADDR=0x203, POINTER_ADDR=0x204.
- One sub-module: sfr_range_check. It is combinational: inputs base and len, output hit, and it handles wrap. It is instantiated twice, for the destination and the source.

Test Plan:
- Write 0x0000<-0xDEAD, then read 0x0000 -> mem_we high for exactly 1 cycle; read rsp_valid 3 cycles after accept; rsp_data=0xDEAD, rsp_err=0.
- Fill addr=0x7FE, len=4, data=0xBEEF -> writes to 0x7FE, 0x7FF, 0x000, 0x001 on consecutive cycles; reading 0x001 returns 0xBEEF; 0x002 is unchanged.
- Copy src=0x000, dst=0x100, len=3 after seeding 0x1111/0x2222/0x3333 -> 6 RAM cycles, then rsp_valid; reads of 0x100-0x102 return the seeded values.
- Fill addr=0x1FE, len=4 (hits 0x200) -> rsp_err=1 one cycle after accept; mem_we never asserts; 0x1FE is unchanged.
- Pointer write 0x204<-0x0001, then read 0x203 -> rsp_data equals the contents of 0x001; fill len=0 -> immediate rsp_err=0 with no mem_we.
- reset_bar pulsed low during a copy -> mem_we=0 and req_ready=1 immediately, no rsp_valid; a subsequent read completes normally.
